// File: rtl/alu_result_buffer.sv
// Purpose : ALU result buffer - queues ALU results (Z + {CY,S,ZR,P,V}) in order for writeback,
//           tracks architectural status flags, a sticky overflow flag and a saturating overflow count.
// Latency : 1 cycle from accepted push to out_valid/out_z (first-word-fall-through, no bypass).
// Backpr. : in_ready = !full from registered occupancy only; a full buffer refuses a push even when
//           the head is popped in the same cycle (the slot frees on the following cycle).
//
// Optional feature macro: ALU_RESULT_BUFFER_FLAG_CHECK_EN
//   defined     -> S/ZR/P are recomputed from Z on each push; any mismatch sets sticky flag_err.
//   not defined -> checker absent, flag_err tied low.
//
// Ports (top, alu_result_buffer):
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready            producer handshake; in_z, in_cy, in_s, in_zr, in_p, in_v = result
//   out_valid/out_ready          consumer handshake; out_z, out_flags {CY,S,ZR,P,V} = head entry
//   stat_flags                   flags of most recently accepted result
//   ovf_sticky, ovf_count        overflow history; ovf_clr clears both (a same-cycle V push wins)
//   fill                         current occupancy 0..DEPTH
//   flag_err                     sticky flag-consistency error (checker build only)

// Generic synchronous FIFO used for the result storage.
// Latency : write visible at rd_dat the cycle after the write edge.
// Backpr. : wr_rdy = !full (registered); rd_vld = !empty (registered); rd_dat is zero when empty.
module alu_result_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          wr_en;
    logic          rd_en;

    assign full   = (fill == FULL_CNT);
    assign wr_rdy = ~full;
    assign rd_vld = (fill != '0);
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_en  = rd_vld & rd_rdy;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own
    // (DEPTH is a power of two). Occupancy is kept separately to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until fill says the slot was written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

endmodule

// ALU result buffer top.
// Latency : 1 cycle push-to-out_valid; status outputs update on the push edge.
// Backpr. : in_ready from registered fill only; no combinational out_ready -> in_ready path.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_z,
    input  logic                     in_cy,
    input  logic                     in_s,
    input  logic                     in_zr,
    input  logic                     in_p,
    input  logic                     in_v,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_z,
    output logic [4:0]               out_flags,
    output logic [4:0]               stat_flags,
    output logic                     ovf_sticky,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     flag_err
);
    localparam int ENTRY_W = 16 + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [15:0] z;
        logic [4:0]  flags;   // {CY,S,ZR,P,V}
    } entry_t;

    entry_t in_entry;
    entry_t head_entry;
    logic   push;
    logic   ovf_push;

    assign in_entry.z     = in_z;
    assign in_entry.flags = {in_cy, in_s, in_zr, in_p, in_v};

    assign push     = in_valid & in_ready;
    assign ovf_push = push & in_v;

    alu_result_buffer_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (in_entry),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head_entry),
        .fill   (fill)
    );

    // FIFO already forces its read data to zero when empty.
    assign out_z     = head_entry.z;
    assign out_flags = head_entry.flags;

    // Architectural status register: flags of the last accepted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flags <= '0;
        end else if (push) begin
            stat_flags <= in_entry.flags;
        end
    end

    // Overflow history. A V push in the same cycle as ovf_clr is not lost:
    // the sticky flag stays set and the counter restarts at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else begin
            if (ovf_push) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end

            if (ovf_clr) begin
                ovf_count <= ovf_push ? CNT_W'(1) : '0;
            end else if (ovf_push && (ovf_count != CNT_MAX)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_RESULT_BUFFER_FLAG_CHECK_EN
    // Recompute the Z-derived flags; CY and V depend on the operands and cannot be checked here.
    logic chk_s;
    logic chk_zr;
    logic chk_p;
    logic flag_mismatch;

    assign chk_s         = in_z[15];
    assign chk_zr        = (in_z == 16'h0000);
    assign chk_p         = ~^in_z;   // even number of ones -> 1
    assign flag_mismatch = (chk_s != in_s) | (chk_zr != in_zr) | (chk_p != in_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_err <= 1'b0;
        end else if (push && flag_mismatch) begin
            flag_err <= 1'b1;
        end
    end
`else
    assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Testbench for alu_result_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_result_buffer;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ALU_RESULT_BUFFER_FLAG_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_z;
    logic              in_cy, in_s, in_zr, in_p, in_v;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_z;
    logic [4:0]        out_flags;
    logic [4:0]        stat_flags;
    logic              ovf_sticky;
    logic              ovf_clr;
    logic [CNT_W-1:0]  ovf_count;
    logic [2:0]        fill;
    logic              flag_err;

    alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_cy      (in_cy),
        .in_s       (in_s),
        .in_zr      (in_zr),
        .in_p       (in_p),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_flags  (out_flags),
        .stat_flags (stat_flags),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .ovf_count  (ovf_count),
        .fill       (fill),
        .flag_err   (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [20:0] q[$];          // {z, cy, s, zr, p, v}
    logic [4:0]  m_stat;
    logic        m_sticky;
    int          m_count;
    logic        m_err;
    bit          m_push, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_stat   = '0;
            m_sticky = 1'b0;
            m_count  = 0;
            m_err    = 1'b0;
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (ovf_clr) begin
                m_sticky = 1'b0;
                m_count  = 0;
            end
            if (m_push) begin
                q.push_back({in_z, in_cy, in_s, in_zr, in_p, in_v});
                m_stat = {in_cy, in_s, in_zr, in_p, in_v};
                if (in_v) begin
                    m_sticky = 1'b1;
                    if (m_count < CNT_MAX) m_count++;
                end
`ifdef ALU_RESULT_BUFFER_FLAG_CHECK_EN
                if ((in_s != (in_z >= 16'h8000)) || (in_zr != (in_z == 16'h0000)) ||
                    (in_p != ($countones(in_z) % 2 == 0)))
                    m_err = 1'b1;
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [20:0] exp_head;
    always @(negedge clk) begin
        exp_head = (q.size() > 0) ? q[0] : 21'h0;
        chk("cmp.out_valid",  out_valid,  q.size() > 0);
        chk("cmp.in_ready",   in_ready,   q.size() < DEPTH);
        chk("cmp.fill",       fill,       q.size());
        chk("cmp.out_z",      out_z,      exp_head[20:5]);
        chk("cmp.out_flags",  out_flags,  exp_head[4:0]);
        chk("cmp.stat_flags", stat_flags, m_stat);
        chk("cmp.ovf_sticky", ovf_sticky, m_sticky);
        chk("cmp.ovf_count",  ovf_count,  m_count);
        chk("cmp.flag_err",   flag_err,   m_err);
    end

    // ---------------- stimulus helpers ----------------
    // Set inputs just after a falling edge, then wait through the rising edge to the next falling edge.
    task automatic drive(input logic v, input logic [15:0] z, input logic [4:0] fl,
                         input logic ordy, input logic clr);
        in_valid  = v;
        in_z      = z;
        {in_cy, in_s, in_zr, in_p, in_v} = fl;
        out_ready = ordy;
        ovf_clr   = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 5'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_reset();
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_z = '0; {in_cy, in_s, in_zr, in_p, in_v} = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.fill", fill, 3'd0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        release_reset();

        // ---- ordered capture, status and overflow tracking ----
        drive(1'b1, 16'h0FFF, 5'b10011, 1'b0, 1'b0);
        chk("t2.latency_vld", out_valid, 1'b1);
        chk("t2.latency_z", out_z, 16'h0FFF);
        drive(1'b1, 16'h8000, 5'b11000, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFF, 5'b11010, 1'b0, 1'b0);
        idle();
        chk("t2.fill", fill, 3'd3);
        chk("t2.stat_flags", stat_flags, 5'b11010);
        chk("t2.ovf_sticky", ovf_sticky, 1'b1);
        chk("t2.ovf_count", ovf_count, 2'd1);
        chk("t2.head0_flags", out_flags, 5'b10011);
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t2.head1_z", out_z, 16'h8000);
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t2.head2_z", out_z, 16'hFFFF);
        chk("t2.head2_flags", out_flags, 5'b11010);
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t2.empty_vld", out_valid, 1'b0);
        chk("t2.empty_z", out_z, 16'h0);

        // ---- full boundary ----
        drive(1'b1, 16'h1111, 5'b00010, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 5'b00010, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 5'b00010, 1'b0, 1'b0);
        drive(1'b1, 16'h4444, 5'b00010, 1'b0, 1'b0);
        chk("t3.full_rdy", in_ready, 1'b0);
        chk("t3.full_fill", fill, 3'd4);
        drive(1'b1, 16'h5555, 5'b00010, 1'b0, 1'b0);
        chk("t3.blocked_fill", fill, 3'd4);
        chk("t3.blocked_head", out_z, 16'h1111);
        drive(1'b1, 16'h5555, 5'b00010, 1'b1, 1'b0);
        chk("t3.pop_only_fill", fill, 3'd3);
        chk("t3.pop_only_rdy", in_ready, 1'b1);
        chk("t3.pop_only_head", out_z, 16'h2222);
        drive(1'b1, 16'h5555, 5'b00010, 1'b0, 1'b0);
        chk("t3.refill", fill, 3'd4);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t3.last_head", out_z, 16'h5555);
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t3.drained", fill, 3'd0);

        // ---- streaming at fill=1, pointer wrap ----
        drive(1'b1, 16'hA000, 5'b10000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 5'b00000, 1'b1, 1'b0);
            chk("t4.fill", fill, 3'd1);
            chk("t4.head", out_z, 16'h0100 + 16'(i));
        end
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t4.drained", out_valid, 1'b0);

        // ---- mid-stream reset ----
        drive(1'b1, 16'h1234, 5'b00011, 1'b0, 1'b0);
        drive(1'b1, 16'h5678, 5'b00011, 1'b0, 1'b0);
        drive(1'b1, 16'h9ABC, 5'b01000, 1'b0, 1'b0);
        chk("t1.pre_fill", fill, 3'd3);
        pulse_reset();
        chk("t1.fill", fill, 3'd0);
        chk("t1.out_valid", out_valid, 1'b0);
        chk("t1.in_ready", in_ready, 1'b1);
        chk("t1.out_z", out_z, 16'h0);
        chk("t1.stat_flags", stat_flags, 5'b0);
        chk("t1.ovf_sticky", ovf_sticky, 1'b0);
        chk("t1.ovf_count", ovf_count, 2'd0);
        chk("t1.flag_err", flag_err, 1'b0);
        release_reset();

        // ---- overflow counter saturation and clear ----
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h7FFF, 5'b00001, 1'b1, 1'b0);
        chk("t5.sat_count", ovf_count, 2'd3);
        chk("t5.sticky", ovf_sticky, 1'b1);
        drive(1'b1, 16'h7FFF, 5'b00001, 1'b1, 1'b1);
        chk("t5.clr_vpush_count", ovf_count, 2'd1);
        chk("t5.clr_vpush_sticky", ovf_sticky, 1'b1);
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b1);
        chk("t5.clr_count", ovf_count, 2'd0);
        chk("t5.clr_sticky", ovf_sticky, 1'b0);
        idle();

        // ---- flag consistency checker ----
        pulse_reset();
        release_reset();
        drive(1'b1, 16'h0000, 5'b00000, 1'b1, 1'b0);
        chk("t6.err_set", flag_err, EXP_ERR);
        drive(1'b1, 16'h0000, 5'b00110, 1'b1, 1'b0);
        drive(1'b1, 16'h8001, 5'b01010, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 5'b0, 1'b1, 1'b0);
        chk("t6.err_sticky", flag_err, EXP_ERR);
        pulse_reset();
        chk("t6.err_rst", flag_err, 1'b0);
        release_reset();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
